alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the single-cycle datapath ALU: a WIDTH-bit arithmetic/logic unit with a registered output stage, valid/ready flow control on both sides, an iterative multi-cycle unsigned multiplier, generic LANE-bit packed saturating add/subtract, and an internal Z/V/N flags register. It sits in the execute stage between operand forwarding and the EX/MEM register. Single-cycle ops stream at one per clock. MUL stalls the unit while it iterates.

## Interface
- WIDTH, 16: datapath width. Must be a multiple of 8 and at least 8.
- LANE, 4: packed-lane width for PADDSB/PSUBSB. Must divide WIDTH and be at least 2.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low; clears all state
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready at a clk edge
- opcode  in  4  operation select (see Operation)
- a, b  in  WIDTH  operands, sampled only on transfer
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result when out_valid & out_ready at a clk edge
- result  out  WIDTH  registered result, stable while out_valid & ~out_ready
- flags  out  3  registered {Z,V,N}
- busy  out  1  multiplier iterating

## Operation
- Opcode map:
  - 0 ADD: signed, saturating to 0x7F..F / 0x80..0.
  - 1 SUB: a−b, signed, saturating.
  - 2 XOR.
  - 3 PSUBSB: per-lane signed saturating a−b.
  - 4 SLL, 5 SRA, 6 ROR: amount = b[log2(WIDTH)-1:0].
  - 7 PADDSB: per-lane signed saturating a+b.
  - 8 MUL: unsigned, result = low WIDTH bits.
  - 9 LLB: (a & ~0xFF) | b[7:0].
  - 10 LHB: (a & 0xFF) | (b[7:0]<<8).
  - 11–15 PASS: result = a.
- Flags are loaded only when a result of opcode 0,1,2,4,5,6,8 enters the result register. Other opcodes hold the flags.
  - ADD/SUB: Z = saturated result==0; V = signed overflow occurred; N = saturated result MSB.
  - XOR/shifts: Z as above; V=0; N=0.
  - MUL: Z = low WIDTH bits==0; V = high WIDTH bits of the full 2·WIDTH product ≠0; N=0.
- Control FSM:
  - IDLE: a transferred non-MUL op writes result/flags and sets out_valid at the same edge. A transferred MUL loads the multiplicand, multiplier, and a zeroed 2·WIDTH accumulator, clears the counter, and goes to MUL.
  - MUL: one shift-add step per cycle. After WIDTH steps, go to DONE.
  - DONE: load result/flags and set out_valid when the result register is free (~out_valid, or out_ready this cycle), then go to IDLE. Otherwise wait in DONE.
- in_ready = (state==IDLE) & (~out_valid | out_ready). A combinational path from out_ready to in_ready is permitted.
- busy = state ∈ {MUL, DONE}.
- out_valid clears on consumption unless a new result loads at the same edge. Simultaneous consume and load keeps out_valid high with the new result.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0.
  - result=0, flags=000, out_valid=0, busy=0.
  - in_ready=1 as soon as rst is high.
  - Reset mid-MUL aborts the operation with no output.
- Non-MUL latency is 1: transfer at edge k gives out_valid from edge k.
- Full throughput is one op per cycle while out_ready=1.
- MUL latency: the transfer edge is k. Steps run on edges k+1…k+WIDTH. DONE loads at edge k+WIDTH+1 at the earliest.
- in_ready is low from edge k until the edge on which DONE loads. A new op may transfer in the cycle after that edge.
- Backpressure: while out_valid & ~out_ready, result and flags are frozen and no op transfers. DONE waits.
- Operands and opcode are ignored when no transfer occurs.

## Test plan
- Reset, then ADD a=0x7FFF b=0x0001 (WIDTH=16) with out_ready=1 → next cycle result=0x7FFF, flags={0,1,0}. Then SUB 0x0005−0x0005 → result=0x0000, flags={1,0,0}.
- PADDSB a=0x7878 b=0x1111 → 0x7979. PSUBSB a=0x8080 b=0x1010 → 0x8080 (saturated lanes). Flags unchanged from the prior op in both cases.
- MUL a=0x0012 b=0x0034 accepted at edge k → in_ready low until the load edge; result=0x03A8, out_valid at edge k+17, flags={0,0,0}. MUL 0x0100·0x0100 → result=0x0000, flags={1,1,0}.
- Back-to-back streaming: XOR, SLL(0x0001,15)=0x8000, SRA(0x8000,3)=0xF000, ROR(0x0001,1)=0x8000 on consecutive cycles → four consecutive results with no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD → result stable, in_ready=0. Release → one cycle of simultaneous consume and accept, no result lost or duplicated.
- Assert rst low 5 cycles into a MUL → outputs immediately zero. After release, a fresh ADD 0x0002+0x0003 → result 0x0005 with latency 1.
- Repeat the ADD and MUL scenarios with WIDTH=32, LANE=8.

Source files
------------

// File: rtl/alu_pipe.sv
// Execute-stage ALU with valid/ready handshake on both sides, a registered result stage,
// an iterative shift-add multiplier and a {Z,V,N} flags register.
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned CNTW  = SHW;
  localparam int unsigned NLANE = WIDTH / LANE;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_PSUBSB = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;
  localparam logic [3:0] OP_MUL    = 4'd8;
  localparam logic [3:0] OP_LLB    = 4'd9;
  localparam logic [3:0] OP_LHB    = 4'd10;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNTW-1:0]      r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0]     r_result, w_result_nxt;
  logic [2:0]           r_flags, w_flags_nxt;
  logic                 r_out_valid, w_out_valid_nxt;

  logic [WIDTH:0]       w_add_ext, w_sub_ext;
  logic                 w_add_ovf, w_sub_ovf;
  logic [WIDTH-1:0]     w_add_sat, w_sub_sat;
  logic [SHW-1:0]       w_sh;
  logic [2*WIDTH-1:0]   w_rot;
  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_v, w_alu_n, w_alu_fld;
  logic [2:0]           w_alu_flags;
  logic                 w_xfer, w_free;

  // Per-lane signed saturating add or subtract
  function automatic logic [WIDTH-1:0] lane_sat(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic sub);
    logic [LANE:0]    s;
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (sub) s = {x[i*LANE+LANE-1], x[i*LANE +: LANE]} - {y[i*LANE+LANE-1], y[i*LANE +: LANE]};
      else     s = {x[i*LANE+LANE-1], x[i*LANE +: LANE]} + {y[i*LANE+LANE-1], y[i*LANE +: LANE]};
      if (s[LANE] != s[LANE-1])
        r[i*LANE +: LANE] = x[i*LANE+LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
      else
        r[i*LANE +: LANE] = s[LANE-1:0];
    end
    return r;
  endfunction

  assign w_add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign w_sub_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign w_add_ovf = w_add_ext[WIDTH] ^ w_add_ext[WIDTH-1];
  assign w_sub_ovf = w_sub_ext[WIDTH] ^ w_sub_ext[WIDTH-1];
  // On overflow the true result has the sign of a
  assign w_add_sat = w_add_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : w_add_ext[WIDTH-1:0];
  assign w_sub_sat = w_sub_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : w_sub_ext[WIDTH-1:0];
  assign w_sh      = b[SHW-1:0];
  assign w_rot     = {a, a} >> w_sh;

  // Single-cycle result and flag candidates
  always_comb begin
    w_alu_res = a;
    w_alu_v   = 1'b0;
    w_alu_n   = 1'b0;
    w_alu_fld = 1'b0;
    case (opcode)
      OP_ADD:    begin w_alu_res = w_add_sat; w_alu_v = w_add_ovf; w_alu_n = w_add_sat[WIDTH-1]; w_alu_fld = 1'b1; end
      OP_SUB:    begin w_alu_res = w_sub_sat; w_alu_v = w_sub_ovf; w_alu_n = w_sub_sat[WIDTH-1]; w_alu_fld = 1'b1; end
      OP_XOR:    begin w_alu_res = a ^ b;                    w_alu_fld = 1'b1; end
      OP_SLL:    begin w_alu_res = a << w_sh;                w_alu_fld = 1'b1; end
      OP_SRA:    begin w_alu_res = WIDTH'($signed(a) >>> w_sh); w_alu_fld = 1'b1; end
      OP_ROR:    begin w_alu_res = w_rot[WIDTH-1:0];         w_alu_fld = 1'b1; end
      OP_PSUBSB: w_alu_res = lane_sat(a, b, 1'b1);
      OP_PADDSB: w_alu_res = lane_sat(a, b, 1'b0);
      OP_LLB:    w_alu_res = (a & ~WIDTH'(8'hFF)) | WIDTH'(b[7:0]);
      OP_LHB:    w_alu_res = (a & WIDTH'(8'hFF)) | (WIDTH'(b[7:0]) << 8);
      default:   w_alu_res = a;
    endcase
    w_alu_flags = {~|w_alu_res, w_alu_v, w_alu_n};
  end

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_xfer    = in_valid && in_ready;
  assign w_free    = !r_out_valid || out_ready;
  assign busy      = (r_state == S_MUL) || (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // Control FSM: next state and datapath register updates
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mcand_nxt     = r_mcand;
    w_mplier_nxt    = r_mplier;
    w_acc_nxt       = r_acc;
    w_result_nxt    = r_result;
    w_flags_nxt     = r_flags;
    w_out_valid_nxt = r_out_valid && !out_ready;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (opcode == OP_MUL) begin
            w_mcand_nxt  = {{WIDTH{1'b0}}, a};
            w_mplier_nxt = b;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_MUL;
          end else begin
            w_result_nxt    = w_alu_res;
            w_out_valid_nxt = 1'b1;
            if (w_alu_fld) w_flags_nxt = w_alu_flags;
          end
        end
      end
      S_MUL: begin
        if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CNTW'(1);
        if (r_cnt == CNTW'(WIDTH - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_free) begin
          w_result_nxt    = r_acc[WIDTH-1:0];
          w_flags_nxt     = {~|r_acc[WIDTH-1:0], |r_acc[2*WIDTH-1:WIDTH], 1'b0};
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_acc       <= w_acc_nxt;
      r_result    <= w_result_nxt;
      r_flags     <= w_flags_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule
